// File: rtl/shreg_ctrl.sv
// Byte-exchange controller for the parallel-load shift register: loads a transmit
// word, clocks it out MSB first over WIDTH cycles while shifting in ser_in, reports rx word.
module shreg_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             bit_valid,
  output logic             sh_ld,
  output logic [WIDTH-1:0] sh_d,
  output logic             sh_si,
  input  logic             sh_so,
  input  logic [WIDTH-1:0] sh_q
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] txr_q, txr_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      txr_q   <= '0;
      rx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txr_q   <= txr_d;
      rx_q    <= rx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txr_d   = txr_q;
    rx_d    = rx_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          txr_d   = tx_data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        // shreg holds the complete received word during this cycle
        rx_d    = sh_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    sh_ld     = (state_q == S_LOAD);
    bit_valid = (state_q == S_SHIFT);
    sh_si     = (state_q == S_SHIFT) ? ser_in : 1'b0;
    ser_out   = (state_q == S_SHIFT) ? sh_so : 1'b0;
    sh_d      = txr_q;
    done      = done_q;
    rx_data   = rx_q;
  end

endmodule
